// File: rtl/spi_block_buffer.sv
// Byte-to-block staging buffer between an SPI slave and an AES core.
// Assembles NBYTES received bytes into a block and streams a processed result back out.
module spi_block_buffer #(
   parameter int NBYTES = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_byte,
   input  logic                  rx_done,
   input  logic                  cs,
   output logic [7:0]            tx_byte,
   output logic [8*NBYTES-1:0]   block_out,
   output logic                  block_valid,
   input  logic [8*NBYTES-1:0]   result_in,
   input  logic                  result_valid,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  overrun
);

   localparam int         BW       = 8 * NBYTES;
   localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

   typedef enum logic [1:0] {COLLECT, WAIT, SEND} state_t;

   state_t            state_reg, state_next;
   logic              cs_q;
   logic [3:0]        rx_cnt_reg, rx_cnt_next;
   logic [3:0]        tx_ptr_reg, tx_ptr_next;
   // Only the first NBYTES-1 bytes need storing; the last one is taken straight from rx_byte.
   logic [BW-9:0]     asm_reg, asm_next;
   logic [BW-1:0]     block_reg, block_next;
   logic              block_valid_reg, block_valid_next;
   logic [BW-1:0]     result_reg, result_next;
   logic              frame_err_reg, frame_err_next;
   logic              overrun_reg, overrun_next;

   logic              cs_fall, cs_rise;
   logic [7:0]        res_bytes [NBYTES];

   assign cs_fall = cs_q & ~cs;
   assign cs_rise = ~cs_q & cs;

   generate
      for (genvar gi = 0; gi < NBYTES; gi++) begin : g_res_bytes
         assign res_bytes[gi] = result_reg[BW-1-8*gi -: 8];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= COLLECT;
         cs_q            <= 1'b1;
         rx_cnt_reg      <= '0;
         tx_ptr_reg      <= '0;
         asm_reg         <= '0;
         block_reg       <= '0;
         block_valid_reg <= 1'b0;
         result_reg      <= '0;
         frame_err_reg   <= 1'b0;
         overrun_reg     <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cs_q            <= cs;
         rx_cnt_reg      <= rx_cnt_next;
         tx_ptr_reg      <= tx_ptr_next;
         asm_reg         <= asm_next;
         block_reg       <= block_next;
         block_valid_reg <= block_valid_next;
         result_reg      <= result_next;
         frame_err_reg   <= frame_err_next;
         overrun_reg     <= overrun_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      rx_cnt_next      = rx_cnt_reg;
      tx_ptr_next      = tx_ptr_reg;
      asm_next         = asm_reg;
      block_next       = block_reg;
      block_valid_next = 1'b0;
      result_next      = result_reg;
      frame_err_next   = 1'b0;
      overrun_next     = overrun_reg;

      case (state_reg)
         COLLECT, SEND: begin
            if (rx_done) begin
               if (rx_cnt_reg == LAST_IDX) begin
                  block_next       = {asm_reg, rx_byte};
                  block_valid_next = 1'b1;
                  rx_cnt_next      = '0;
                  state_next       = WAIT;
               end else begin
                  asm_next    = {asm_reg[BW-17:0], rx_byte};
                  rx_cnt_next = rx_cnt_reg + 4'd1;
               end
            end
            if (result_valid) begin
               overrun_next = 1'b1;
            end
            if (state_reg == SEND) begin
               if (rx_done && tx_ptr_reg != LAST_IDX) begin
                  tx_ptr_next = tx_ptr_reg + 4'd1;
               end
               // Byte 0 was already loaded while cs was high, so the first reload must fetch byte 1.
               if (cs_fall) begin
                  tx_ptr_next = 4'd1;
               end
            end
         end
         WAIT: begin
            if (rx_done) begin
               overrun_next = 1'b1;
            end
            if (result_valid) begin
               result_next = result_in;
               tx_ptr_next = '0;
               state_next  = SEND;
            end
         end
         default: state_next = COLLECT;
      endcase

      // Abort is judged on the post-byte count, so a completing final byte never aborts.
      if (cs_rise && rx_cnt_next != 4'd0) begin
         rx_cnt_next    = '0;
         asm_next       = '0;
         frame_err_next = 1'b1;
         if (state_reg == SEND) begin
            tx_ptr_next = '0;
         end
      end
   end

   always_comb begin
      tx_byte = 8'h00;
      if (state_reg == SEND) begin
         tx_byte = cs_q ? res_bytes[0] : res_bytes[tx_ptr_reg];
      end
   end

   assign block_out   = block_reg;
   assign block_valid = block_valid_reg;
   assign busy        = (state_reg == WAIT);
   assign frame_err   = frame_err_reg;
   assign overrun     = overrun_reg;

endmodule

// File: tb/tb_spi_block_buffer.sv
// Directed bench for spi_block_buffer: block assembly, result streaming, aborts, overrun and async reset.
module tb_spi_block_buffer;

   logic         clk;
   logic         reset;
   logic [7:0]   rx_byte;
   logic         rx_done;
   logic         cs;
   logic [7:0]   tx_byte;
   logic [127:0] block_out;
   logic         block_valid;
   logic [127:0] result_in;
   logic         result_valid;
   logic         busy;
   logic         frame_err;
   logic         overrun;

   int n_checks = 0;
   int n_pass   = 0;

   spi_block_buffer #(.NBYTES(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_byte      (rx_byte),
      .rx_done      (rx_done),
      .cs           (cs),
      .tx_byte      (tx_byte),
      .block_out    (block_out),
      .block_valid  (block_valid),
      .result_in    (result_in),
      .result_valid (result_valid),
      .busy         (busy),
      .frame_err    (frame_err),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_byte = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic load_result(input logic [127:0] r);
      result_in    = r;
      result_valid = 1'b1;
      tick();
      result_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; cs = 1'b1; rx_done = 1'b0; rx_byte = 8'h00;
      result_valid = 1'b0; result_in = '0;
      tick(); tick();
      check("rst_tx_byte", tx_byte, 8'h00);
      check("rst_block_out", block_out, 128'h0);
      check("rst_block_valid", block_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      reset = 1'b1;
      tick();

      // Plain block assembly
      cs = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      $display("block A: %h valid=%0b", block_out, block_valid);
      check("blkA_valid", block_valid, 1'b1);
      check("blkA_data", block_out, 128'h000102030405060708090A0B0C0D0E0F);
      check("blkA_busy", busy, 1'b1);
      check("blkA_ferr", frame_err, 1'b0);
      cs = 1'b1;
      tick();
      check("blkA_valid_pulse", block_valid, 1'b0);
      tick();
      check("idle_rise_no_ferr", frame_err, 1'b0);

      // Byte arriving while waiting for the core
      send_byte(8'h55);
      $display("wait-drop: overrun=%0b", overrun);
      check("wait_overrun", overrun, 1'b1);
      check("wait_block_kept", block_out, 128'h000102030405060708090A0B0C0D0E0F);
      check("wait_busy", busy, 1'b1);
      tick();
      check("wait_overrun_sticky", overrun, 1'b1);

      // Stream result A0..AF out while a new block comes in
      load_result(128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
      check("send_busy", busy, 1'b0);
      check("send_idle_tx", tx_byte, 8'hA0);
      cs = 1'b0;
      #1;
      check("tx_byte[0]", tx_byte, 8'hA0);
      tick();
      for (int i = 0; i < 16; i++) begin
         rx_byte = 8'(8'h10 + i);
         rx_done = 1'b1;
         #1;
         if (i < 15) check($sformatf("tx_byte[%0d]", i + 1), tx_byte, 8'(8'hA1 + i));
         tick();
         rx_done = 1'b0;
      end
      $display("block B: %h valid=%0b", block_out, block_valid);
      check("blkB_valid", block_valid, 1'b1);
      check("blkB_data", block_out, 128'h101112131415161718191A1B1C1D1E1F);
      check("blkB_busy", busy, 1'b1);
      check("blkB_tx_zero", tx_byte, 8'h00);

      // Frame abort after 5 bytes during SEND
      load_result(128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF);
      check("abort_tx0", tx_byte, 8'hB0);
      for (int i = 0; i < 5; i++) send_byte(8'(8'hE0 + i));
      check("abort_tx5", tx_byte, 8'hB5);
      cs = 1'b1;
      tick();
      $display("abort: frame_err=%0b", frame_err);
      check("abort_ferr", frame_err, 1'b1);
      check("abort_state_kept", busy, 1'b0);
      tick();
      check("abort_ferr_pulse", frame_err, 1'b0);
      cs = 1'b0;
      tick();
      check("abort_reload_tx1", tx_byte, 8'hB1);
      for (int i = 0; i < 15; i++) begin
         send_byte(8'(8'h20 + i));
         if (block_valid) check("abort_early_block", block_valid, 1'b0);
      end
      send_byte(8'h2F);
      $display("block C: %h valid=%0b", block_out, block_valid);
      check("blkC_valid", block_valid, 1'b1);
      check("blkC_data", block_out, 128'h202122232425262728292A2B2C2D2E2F);

      // Final byte coincident with cs rising
      load_result(128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF);
      for (int i = 0; i < 15; i++) send_byte(8'(8'h30 + i));
      rx_byte = 8'h3F; rx_done = 1'b1; cs = 1'b1;
      tick();
      rx_done = 1'b0;
      $display("block D: %h valid=%0b ferr=%0b", block_out, block_valid, frame_err);
      check("blkD_valid", block_valid, 1'b1);
      check("blkD_ferr", frame_err, 1'b0);
      check("blkD_data", block_out, 128'h303132333435363738393A3B3C3D3E3F);
      check("blkD_busy", busy, 1'b1);
      cs = 1'b0;
      tick();

      // Asynchronous reset in the middle of SEND
      load_result(128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
      for (int i = 0; i < 3; i++) send_byte(8'(8'h50 + i));
      check("pre_rst_overrun", overrun, 1'b1);
      check("pre_rst_tx", tx_byte, 8'hC3);
      #2;
      reset = 1'b0;
      #1;
      $display("async reset at %0t", $time);
      check("arst_tx_byte", tx_byte, 8'h00);
      check("arst_block_out", block_out, 128'h0);
      check("arst_block_valid", block_valid, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_frame_err", frame_err, 1'b0);
      check("arst_overrun", overrun, 1'b0);
      tick();
      reset = 1'b1;
      tick();

      // Stray result in COLLECT, then a full block counted from byte 0
      load_result(128'hFFFF);
      check("collect_result_overrun", overrun, 1'b1);
      check("collect_result_ignored", busy, 1'b0);
      check("collect_tx_zero", tx_byte, 8'h00);
      for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
      $display("block E: %h valid=%0b", block_out, block_valid);
      check("blkE_valid", block_valid, 1'b1);
      check("blkE_data", block_out, 128'h404142434445464748494A4B4C4D4E4F);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_block_buffer.md
SPI_BLOCK_BUFFER -- requirements
Module: spi_block_buffer

Interface
REQ-001: Parameter NBYTES, default 16, bytes per block (block width 8*NBYTES = 128 bits).
REQ-002: clk  input  1  system clock; all state updates on its rising edge.
REQ-003: reset  input  1  asynchronous, active-low; asserting it (0) clears all state immediately, independent of clk.
REQ-004: rx_byte  input  8  byte received by the SPI slave; valid only in cycles where rx_done=1.
REQ-005: rx_done  input  1  single-cycle pulse from the SPI slave at the end of each byte transfer.
REQ-006: cs  input  1  SPI chip select, active low, taken directly from the bus pin.
REQ-007: tx_byte  output  8  byte offered to the SPI slave as its next byte to send.
REQ-008: block_out  output  128  assembled block; first byte received occupies [127:120].
REQ-009: block_valid  output  1  single-cycle pulse; block_out is valid in that cycle and stays stable until the next block completes.
REQ-010: result_in  input  128  processed block from the AES core; first byte to send is [127:120].
REQ-011: result_valid  input  1  single-cycle pulse qualifying result_in.
REQ-012: busy  output  1  high in WAIT.
REQ-013: frame_err  output  1  single-cycle pulse on a frame abort.
REQ-014: overrun  output  1  sticky flag; set on a dropped byte or dropped result; cleared only by reset.

Function
REQ-015: cs shall be registered once (cs_q); a falling edge is cs_q=1 -> cs=0 as sampled; a rising edge is the reverse.
REQ-016: The FSM shall have exactly three states: COLLECT (reset state), WAIT, and SEND.
REQ-017: A 4-bit rx_cnt shall count received bytes 0..NBYTES-1. A 4-bit tx_ptr shall select result byte tx_ptr for tx_byte.
REQ-018: COLLECT/SEND: on rx_done, the assembly register shall shift left 8 bits with rx_byte entering [7:0], and rx_cnt shall increment.
REQ-019: When rx_done arrives with rx_cnt=NBYTES-1: block_out shall load the completed value next cycle, block_valid shall pulse that same cycle, rx_cnt shall wrap to 0, and the FSM shall go to WAIT.
REQ-020: Latency: block_valid shall be asserted exactly 1 cycle after the 16th rx_done.
REQ-021: WAIT: rx_done shall be dropped, overrun set, and rx_cnt left unchanged.
REQ-022: WAIT: result_valid shall latch result_in into the result register, set tx_ptr=0, and move the FSM to SEND in the next cycle.
REQ-023: result_valid in COLLECT or SEND shall be ignored, and overrun set.
REQ-024: SEND, while cs_q=1: tx_byte shall be result byte 0.
REQ-025: SEND, on a cs falling edge: tx_ptr shall become 1, so the slave's end-of-byte reload fetches byte 1.
REQ-026: SEND, on each rx_done: tx_ptr shall increment, saturating at NBYTES-1.
REQ-027: tx_byte shall be 8'h00 outside SEND.
REQ-028: On a cs rising edge with rx_cnt!=0, the block shall treat it as a frame abort: rx_cnt=0, partial block discarded, frame_err pulsed, and tx_ptr reset to 0 if in SEND; the state is unchanged.
REQ-029: On a cs rising edge with rx_cnt=0, the block shall take no action and shall not assert frame_err.
REQ-030: rx_done and a cs rising edge in the same cycle shall process the byte first, then evaluate the abort using the updated rx_cnt (a completing 16th byte is not an abort).
REQ-031: Full duplex: bytes received in SEND form the next input block; completion of that block (REQ-019) shall move the FSM SEND -> WAIT.

Reset
REQ-032: While reset=0, the block shall hold: state=COLLECT, rx_cnt=0, tx_ptr=0, block_out=0, result register=0, tx_byte=0, block_valid=0, busy=0, frame_err=0, overrun=0.
REQ-033: Reset asserted mid-frame shall discard all partial data. After release, the first rx_done shall be treated as byte 0.

Verification
REQ-034: cs low, 16 rx_done pulses with bytes 00..0F -> block_valid 1 cycle after the 16th pulse, block_out=128'h000102...0F, busy=1.
REQ-035: In WAIT, result_valid with result_in=128'hA0A1...AF, then cs low and 16 bytes -> slave-observed tx_byte sequence A0,A1,...,AF; FSM -> WAIT after the 16th byte.
REQ-036: 5 bytes received, then cs high -> frame_err pulses once, rx_cnt=0; the next 16 bytes yield a clean block.
REQ-037: rx_done while in WAIT -> overrun=1 and remains 1; block_out unchanged.
REQ-038: reset driven low asynchronously mid-SEND, between clock edges -> all outputs equal REQ-032 values before the next clk edge.
REQ-039: 16th rx_done coincident with a cs rising edge -> block_valid=1, frame_err=0.
